cavlc_vlc_packer: RTL and testbench

//  Downstream of the CAVLC VLC tables (TotalZeros, CoeffToken, RunBefore, level codes); packs

---
 rtl/cavlc_vlc_packer.sv | 151 +++++++++++++++
 tb/tb_cavlc_vlc_packer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cavlc_vlc_packer.sv
// CAVLC bit packer: appends variable-length {code,len} pairs MSB-first into OUT_W-bit words,
// with a flush that drains the buffer and zero-pads the final partial word.
module cavlc_vlc_packer #(
    parameter int CODE_W = 16,
    parameter int LEN_W  = 5,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [5:0]        out_nbits,
    output logic              out_last,
    output logic              flush_done,
    output logic [23:0]       total_bits,
    output logic              len_err
);

    localparam int BUF_W = OUT_W + CODE_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] OUT_CNT  = CNT_W'(OUT_W);
    localparam logic [LEN_W-1:0] CODE_LEN = LEN_W'(CODE_W);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [BUF_W-1:0]  buf_r, buf_nxt_s, buf_pop_s, app_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_pop_s;
    logic [23:0]       total_r;
    logic              len_err_r;
    logic [LEN_W-1:0]  len_sat_s;
    logic [CODE_W-1:0] code_mask_s, code_lj_s;
    logic              push_s, pop_s;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        if (len > CODE_LEN) begin
            sat_len = CODE_LEN;
        end else begin
            sat_len = len;
        end
    endfunction

    // Handshake and output decode, all from registered state
    always_comb begin
        in_ready = (state_r == ST_RUN) && (cnt_r <= OUT_CNT);
        case (state_r)
            ST_RUN:   out_valid = (cnt_r >= OUT_CNT);
            ST_FLUSH: out_valid = (cnt_r != {CNT_W{1'b0}});
            default:  out_valid = 1'b0;
        endcase
        out_data   = buf_r[BUF_W-1 -: OUT_W];
        out_nbits  = (cnt_r >= OUT_CNT) ? 6'(OUT_W) : 6'(cnt_r);
        out_last   = (state_r == ST_FLUSH) && (cnt_r <= OUT_CNT);
        flush_done = (state_r == ST_DONE);
        total_bits = total_r;
        len_err    = len_err_r;
        push_s     = in_valid && in_ready;
        pop_s      = out_valid && out_ready;
    end

    // Code alignment: keep the low L bits, then left-justify them within CODE_W
    always_comb begin
        len_sat_s   = sat_len(in_len);
        code_mask_s = in_code & ~({CODE_W{1'b1}} << len_sat_s);
        code_lj_s   = code_mask_s << (CODE_LEN - len_sat_s);
    end

    // Buffer update (pop first, then append at post-pop count) and state transitions
    always_comb begin
        state_nxt_s = state_r;
        if (pop_s) begin
            buf_pop_s = buf_r << OUT_W;
            cnt_pop_s = (cnt_r >= OUT_CNT) ? (cnt_r - OUT_CNT) : {CNT_W{1'b0}};
        end else begin
            buf_pop_s = buf_r;
            cnt_pop_s = cnt_r;
        end
        if (push_s) begin
            app_s     = {code_lj_s, {OUT_W{1'b0}}} >> cnt_pop_s;
            cnt_nxt_s = cnt_pop_s + CNT_W'(len_sat_s);
        end else begin
            app_s     = {BUF_W{1'b0}};
            cnt_nxt_s = cnt_pop_s;
        end
        buf_nxt_s = buf_pop_s | app_s;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else if (pop_s && out_last) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_RUN;
                buf_nxt_s   = {BUF_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_RUN;
                buf_nxt_s   = {BUF_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, buffer and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            buf_r     <= {BUF_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            total_r   <= 24'd0;
            len_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            buf_r   <= buf_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (push_s) begin
                total_r <= total_r + 24'(len_sat_s);
            end else begin
                total_r <= total_r;
            end
            if (push_s && (in_len > CODE_LEN)) begin
                len_err_r <= 1'b1;
            end else begin
                len_err_r <= len_err_r;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_vlc_packer.sv
// Directed bench for cavlc_vlc_packer: per-cycle vectors of inputs and the outputs expected
// just after the following rising edge.
module tb_cavlc_vlc_packer;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_code;
    logic [4:0]  in_len;
    logic [31:0] out_data;
    logic [5:0]  out_nbits;
    logic        out_last, flush_done, len_err;
    logic [23:0] total_bits;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst, v;
        logic [15:0] code;
        logic [4:0]  len;
        logic        fl, ordy;
        logic        e_ov;
        logic [31:0] e_data;
        logic [5:0]  e_nb;
        logic        e_last, e_ir, e_fd;
        logic [23:0] e_tb;
        logic        e_le;
    } vec_t;

    vec_t tbl[$];

    cavlc_vlc_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_len(in_len), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nbits(out_nbits), .out_last(out_last), .flush_done(flush_done),
        .total_bits(total_bits), .len_err(len_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] code,
                                input logic [4:0] len, input logic fl, input logic ordy,
                                input logic e_ov, input logic [31:0] e_data, input logic [5:0] e_nb,
                                input logic e_last, input logic e_ir, input logic e_fd,
                                input logic [23:0] e_tb, input logic e_le);
        vec_t x;
        x.rst = r; x.v = v; x.code = code; x.len = len; x.fl = fl; x.ordy = ordy;
        x.e_ov = e_ov; x.e_data = e_data; x.e_nb = e_nb; x.e_last = e_last;
        x.e_ir = e_ir; x.e_fd = e_fd; x.e_tb = e_tb; x.e_le = e_le;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        rst = x.rst; in_valid = x.v; in_code = x.code; in_len = x.len;
        flush = x.fl; out_ready = x.ordy;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"},  32'(out_valid),  32'(x.e_ov));
        chk({tag, ".out_data"},   out_data,        x.e_data);
        chk({tag, ".out_nbits"},  32'(out_nbits),  32'(x.e_nb));
        chk({tag, ".out_last"},   32'(out_last),   32'(x.e_last));
        chk({tag, ".in_ready"},   32'(in_ready),   32'(x.e_ir));
        chk({tag, ".flush_done"}, 32'(flush_done), 32'(x.e_fd));
        chk({tag, ".total_bits"}, 32'(total_bits), 32'(x.e_tb));
        chk({tag, ".len_err"},    32'(len_err),    32'(x.e_le));
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] ones;
        pat  = 32'h6DB6DB6D;
        ones = 32'hFFFFFFFF;

        // reset state
        apply(mk(1, 0, 16'h0, 5'd0, 0, 0,  0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0), "reset0");
        apply(mk(1, 0, 16'h0, 5'd0, 0, 0,  0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0), "reset1");

        // eleven "011" codes form one full word with one bit left over
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0, 1, 16'h3, 5'd3, 0, 1, 0, pat & ~(ones >> (3 * k)),
                             6'(3 * k), 0, 1, 0, 24'(3 * k), 0));
        tbl.push_back(mk(0, 1, 16'h3, 5'd3, 0, 1,  1, 32'h6DB6DB6D, 6'd32, 0, 0, 0, 24'd33, 0));
        tbl.push_back(mk(0, 0, 16'h0, 5'd0, 0, 1,  0, 32'h80000000, 6'd1, 0, 1, 0, 24'd33, 0));
        tbl.push_back(mk(0, 0, 16'h0, 5'd0, 1, 0,  1, 32'h80000000, 6'd1, 1, 0, 0, 24'd33, 0));
        tbl.push_back(mk(0, 0, 16'h0, 5'd0, 0, 1,  0, 32'h0, 6'd0, 0, 0, 1, 24'd33, 0));
        tbl.push_back(mk(0, 0, 16'h0, 5'd0, 0, 1,  0, 32'h0, 6'd0, 0, 1, 0, 24'd33, 0));
        // zero-length code is a no-op; only the low bit of the next code is kept
        tbl.push_back(mk(0, 1, 16'h7, 5'd0, 0, 1,  0, 32'h0, 6'd0, 0, 1, 0, 24'd33, 0));
        tbl.push_back(mk(0, 1, 16'hFFFE, 5'd1, 0, 1, 0, 32'h0, 6'd1, 0, 1, 0, 24'd34, 0));
        tbl.push_back(mk(1, 0, 16'h0, 5'd0, 0, 1,  0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0));
        // over-long length saturates to 16 bits and sets the sticky error
        tbl.push_back(mk(0, 1, 16'hFFFF, 5'd20, 0, 1, 0, 32'hFFFF0000, 6'd16, 0, 1, 0, 24'd16, 1));
        tbl.push_back(mk(0, 0, 16'h0, 5'd0, 0, 0,  0, 32'hFFFF0000, 6'd16, 0, 1, 0, 24'd16, 1));
        tbl.push_back(mk(1, 0, 16'h0, 5'd0, 0, 0,  0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // backpressure: three 16-bit codes fill 48 bits, word held stable, then pop + merge
        apply(mk(0, 1, 16'hFFFF, 5'd16, 0, 0, 0, 32'hFFFF0000, 6'd16, 0, 1, 0, 24'd16, 0), "bp1");
        apply(mk(0, 1, 16'hFFFF, 5'd16, 0, 0, 1, 32'hFFFFFFFF, 6'd32, 0, 1, 0, 24'd32, 0), "bp2");
        apply(mk(0, 1, 16'hFFFF, 5'd16, 0, 0, 1, 32'hFFFFFFFF, 6'd32, 0, 0, 0, 24'd48, 0), "bp3");
        apply(mk(0, 1, 16'h1111, 5'd16, 0, 0, 1, 32'hFFFFFFFF, 6'd32, 0, 0, 0, 24'd48, 0), "bphold");
        apply(mk(0, 0, 16'h0, 5'd0, 0, 1, 0, 32'hFFFF0000, 6'd16, 0, 1, 0, 24'd48, 0), "bppop");
        apply(mk(0, 1, 16'h1234, 5'd16, 0, 1, 1, 32'hFFFF1234, 6'd32, 0, 1, 0, 24'd64, 0), "fill32");
        apply(mk(0, 1, 16'hABCD, 5'd16, 0, 1, 0, 32'hABCD0000, 6'd16, 0, 1, 0, 24'd80, 0), "popush");

        // reset mid-stream discards 20 buffered bits; a following flush emits nothing
        apply(mk(1, 0, 16'h0, 5'd0, 0, 1, 0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0), "rst2");
        apply(mk(0, 1, 16'hFFFF, 5'd16, 0, 1, 0, 32'hFFFF0000, 6'd16, 0, 1, 0, 24'd16, 0), "p16");
        apply(mk(0, 1, 16'h000F, 5'd4, 0, 1, 0, 32'hFFFFF000, 6'd20, 0, 1, 0, 24'd20, 0), "p20");
        apply(mk(1, 0, 16'h0, 5'd0, 0, 1, 0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0), "rst20");
        apply(mk(0, 0, 16'h0, 5'd0, 1, 1, 0, 32'h0, 6'd0, 1, 0, 0, 24'd0, 0), "efl1");
        apply(mk(0, 0, 16'h0, 5'd0, 0, 1, 0, 32'h0, 6'd0, 0, 0, 1, 24'd0, 0), "efl2");
        apply(mk(0, 0, 16'h0, 5'd0, 0, 1, 0, 32'h0, 6'd0, 0, 1, 0, 24'd0, 0), "efl3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
